// File: rtl/req_arbiter_4_if.sv
// rtl/req_arbiter_4_if.sv - request/grant bundle for the 4-way arbiter
//
// Signals:
//   req      [3:0]  request per requester, req[3] highest fixed priority
//   gnt      [3:0]  one-hot grant, zero when nothing is granted
//   gnt_id   [1:0]  binary index of the granted requester
//   gnt_vld         high while gnt is non-zero
// Modports:
//   master  requester side: drives req, observes the grant
//   slave   arbiter side: observes req, drives the grant
interface req_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_vld
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_vld
  );
endinterface

// File: rtl/req_arbiter_4.sv
// rtl/req_arbiter_4.sv - 4-requester arbiter with bounded grant length
//
// Purpose: grants one of four requesters at a time. A grant is held until
// the owner drops its request or has held it for MAX_HOLD cycles; it is
// never preempted. On release another requester is granted at the same
// edge; a timed-out owner that is the only requester sees one idle cycle.
// Optional macro ARB_ROUND_ROBIN_EN: search order becomes last_id-1,
// last_id-2, last_id-3, last_id (mod 4); otherwise fixed 3,2,1,0.
//
// Ports:
//   clk    input   single clock, rising edge
//   rst_n  input   asynchronous active-low reset
//   bus    slave   req in; registered gnt, gnt_id, gnt_vld out
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per requester (2..16)
module req_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  req_arbiter_4_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [3:0] hold_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_id;
  logic [1:0] cand_id;
`endif

  logic       release_now;
  logic [3:0] others;
  logic       win_vld;
  logic [1:0] win_id;

  always_comb begin
    release_now = (state == GRANT) &&
                  (!bus.req[bus.gnt_id] || (hold_cnt == 4'(MAX_HOLD - 1)));

    // The current owner never competes in its own release arbitration,
    // which is what forces the idle cycle after a lone timeout.
    others = bus.req;
    if (state == GRANT) begin
      others[bus.gnt_id] = 1'b0;
    end
    win_vld = |others;
    win_id  = 2'd0;

`ifdef ARB_ROUND_ROBIN_EN
    cand_id = 2'd0;
    // Walk from lowest to highest precedence so the last hit wins;
    // k=0 is last_id-1 (highest), k=3 wraps to last_id (lowest).
    for (int k = 3; k >= 0; k--) begin
      cand_id = last_id - 2'(k + 1);
      if (others[cand_id]) begin
        win_id = cand_id;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (others[k]) begin
        win_id = 2'(k);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.gnt     <= 4'b0000;
      bus.gnt_id  <= 2'b00;
      bus.gnt_vld <= 1'b0;
      hold_cnt    <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id     <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state       <= GRANT;
            bus.gnt     <= 4'b0001 << win_id;
            bus.gnt_id  <= win_id;
            bus.gnt_vld <= 1'b1;
            hold_cnt    <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_id     <= win_id;
`endif
          end else begin
            bus.gnt     <= 4'b0000;
            bus.gnt_vld <= 1'b0;
          end
        end
        GRANT: begin
          if (!release_now) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else if (win_vld) begin
            bus.gnt     <= 4'b0001 << win_id;
            bus.gnt_id  <= win_id;
            bus.gnt_vld <= 1'b1;
            hold_cnt    <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_id     <= win_id;
`endif
          end else begin
            state       <= IDLE;
            bus.gnt     <= 4'b0000;
            bus.gnt_vld <= 1'b0;
            hold_cnt    <= 4'd0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.gnt     <= 4'b0000;
          bus.gnt_vld <= 1'b0;
          hold_cnt    <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter_4.sv
// tb/tb_req_arbiter_4.sv - self-checking bench for req_arbiter_4
module tb_req_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  req_arbiter_4_if bus ();

  req_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index (-1 when idle), number of cycles it has shown a grant.
  int         m_owner;
  int         m_run;
  logic [1:0] m_id;
  logic [1:0] m_last;

  function automatic int winner(logic [3:0] cand);
    int order [4];
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      order[k] = (int'(m_last) + 3 - k) % 4;
`else
      order[k] = 3 - k;
`endif
    end
    for (int k = 0; k < 4; k++) begin
      if (cand[order[k]]) return order[k];
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int         w;
    logic [3:0] cand;
    if (!rst_n) begin
      m_owner <= -1;
      m_run   <= 0;
      m_id    <= 2'd0;
      m_last  <= 2'd0;
    end else begin
      if (m_owner >= 0 && bus.req[m_owner] && m_run < MAX_HOLD) begin
        m_run <= m_run + 1;
      end else begin
        cand = bus.req;
        if (m_owner >= 0) cand[m_owner] = 1'b0;
        w = winner(cand);
        if (w >= 0) begin
          m_owner <= w;
          m_run   <= 1;
          m_id    <= 2'(w);
          m_last  <= 2'(w);
        end else begin
          m_owner <= -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    if (rst_n) begin
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      total++;
      if (bus.gnt !== exp_gnt) begin
        bad++;
        $display("FAIL model_gnt t=%0t got %b want %b", $time, bus.gnt, exp_gnt);
      end
      total++;
      if (bus.gnt_id !== m_id) begin
        bad++;
        $display("FAIL model_gnt_id t=%0t got %0d want %0d", $time, bus.gnt_id, m_id);
      end
      total++;
      if (bus.gnt_vld !== (m_owner >= 0)) begin
        bad++;
        $display("FAIL model_gnt_vld t=%0t got %b want %b", $time, bus.gnt_vld, (m_owner >= 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] seq [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
  logic [1:0] seq [5] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
`endif

  initial begin
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    check("reset_gnt", bus.gnt, 4'b0000);
    check("reset_gnt_id", {2'b00, bus.gnt_id}, 4'd0);
    check("reset_gnt_vld", {3'b000, bus.gnt_vld}, 4'd0);

    rst_n   = 1'b1;
    bus.req = 4'b0101;
    tick();
    check("first_gnt", bus.gnt, 4'b0100);
    check("first_gnt_id", {2'b00, bus.gnt_id}, 4'd2);
    check("first_gnt_vld", {3'b000, bus.gnt_vld}, 4'd1);

    bus.req = 4'b0001;
    tick();
    check("handoff_gnt", bus.gnt, 4'b0001);
    check("handoff_vld", {3'b000, bus.gnt_vld}, 4'd1);

    bus.req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_preempt", bus.gnt, 4'b0001);
    end
    // Glitch on req[0] between edges must not be seen.
    #3 bus.req = 4'b1000;
    #2 bus.req = 4'b1001;
    tick();
    check("glitch_ignored", bus.gnt, 4'b0001);

    bus.req = 4'b1000;
    tick();
    check("switch_to_3", bus.gnt, 4'b1000);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      check("timeout_hold", bus.gnt, 4'b1000);
    end
    tick();
    check("timeout_idle", {3'b000, bus.gnt_vld}, 4'd0);
    tick();
    check("regrant", bus.gnt, 4'b1000);
    bus.req = 4'b0000;
    tick();
    check("drop_idle", {3'b000, bus.gnt_vld}, 4'd0);

    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      tick();
      check("seq_start_id", {2'b00, bus.gnt_id}, {2'b00, seq[w]});
      check("seq_start_gnt", bus.gnt, 4'b0001 << seq[w]);
      for (int i = 0; i < MAX_HOLD - 2; i++) tick();
      tick();
      check("seq_end_id", {2'b00, bus.gnt_id}, {2'b00, seq[w]});
    end

    #3 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", bus.gnt, 4'b0000);
    check("async_rst_vld", {3'b000, bus.gnt_vld}, 4'd0);
    check("async_rst_id", {2'b00, bus.gnt_id}, 4'd0);
    tick();
    check("rst_held_gnt", bus.gnt, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt", bus.gnt, 4'b1000);
    bus.req = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/req_arbiter_4.md
REQ_ARBITER_4 -- requirements
Module: req_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per requester (legal 2..16).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port req  input  4  request per requester; req[3] is the highest fixed priority.
REQ-005 The block SHALL have port gnt  output  4  registered one-hot grant (all zero when no grant).
REQ-006 The block SHALL have port gnt_id  output  2  registered binary index of the granted requester.
REQ-007 The block SHALL have port gnt_vld  output  1  registered flag, high while gnt is non-zero.

Function
REQ-008 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-009 In IDLE with req != 0, the block SHALL enter GRANT at the next edge with the arbitration winner in gnt/gnt_id, gnt_vld=1 and hold_cnt=0 (one-cycle request-to-grant latency).
REQ-010 In IDLE with req == 0, the block SHALL remain in IDLE with gnt=0, gnt_id unchanged, gnt_vld=0.
REQ-011 In GRANT, hold_cnt (4 bits) SHALL increment by 1 each cycle the grant is held.
REQ-012 The grant SHALL be released at the edge where req[gnt_id]==0 or hold_cnt==MAX_HOLD-1, whichever occurs first; the maximum grant length is therefore MAX_HOLD cycles.
REQ-013 On release, if any req bit other than the current gnt_id is high, the block SHALL grant that bit's winner at the same edge with hold_cnt=0 and no idle gap.
REQ-014 On release with no other requester, the block SHALL go to IDLE (gnt=0, gnt_vld=0).
REQ-015 A requester whose grant expired by timeout and that still requests SHALL therefore get at least one IDLE cycle or another requester's turn before it is re-granted.
REQ-016 Requests arriving while a grant is held SHALL NOT preempt it, including higher-priority requests.
REQ-017 gnt SHALL always be one-hot or zero and SHALL equal (gnt_vld ? 1<<gnt_id : 0).
REQ-018 A requester dropping and re-raising req within the same cycle window SHALL be treated only by the sampled value at each edge.

Reset
REQ-019 Asserting rst_n low SHALL immediately force state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_vld=0, hold_cnt=0 and last_id=2'b00, regardless of clk.
REQ-020 Reset asserted mid-grant SHALL abort the grant with no completion cycle.
REQ-021 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n high.

Configuration
REQ-022 Macro ARB_ROUND_ROBIN_EN: when defined, the search order SHALL be last_id-1, last_id-2, last_id-3, last_id (mod 4), where last_id is updated to each new grant's index.
REQ-023 With ARB_ROUND_ROBIN_EN defined, the reset value last_id=0 SHALL give the initial order 3,2,1,0.
REQ-024 When ARB_ROUND_ROBIN_EN is undefined, the search order SHALL be fixed at 3,2,1,0 and last_id SHALL be absent or unused.

Verification
REQ-025 The bench SHALL cover: reset, req=4'b0101 at cycle 0 -> at edge 1 gnt=0100, gnt_id=2, gnt_vld=1.
REQ-026 The bench SHALL cover: grant on 2, req[2] dropped with req=4'b0001 -> next edge gnt=0001 with no IDLE cycle.
REQ-027 The bench SHALL cover: req=4'b1000 held constant, MAX_HOLD=8 -> gnt=1000 for exactly 8 cycles, one IDLE cycle (gnt_vld=0), then re-grant.
REQ-028 The bench SHALL cover: grant on 0, then req[3] raised -> gnt stays 0001 until req[0] drops or timeout.
REQ-029 The bench SHALL cover: req=4'b1111 held with ARB_ROUND_ROBIN_EN -> grant sequence 3,2,1,0,3 at 8-cycle intervals; without the macro -> the sequence is 3,2,3,2 (3 re-wins after 2's turn).
REQ-030 The bench SHALL cover: rst_n pulled low between clock edges mid-grant -> gnt=0 and gnt_vld=0 immediately, before the next clk edge.
